tick_divider: RTL
=================

Name: tick_divider

Overview:
- Parametrised synchronous successor to the ripple clock divider.
- Everything runs on one clock, clock100. The block produces single-cycle enable pulses; it does not produce derived clocks.
- Pulses: pix_tick every PIX_DIV cycles for the VGA pipeline, and game_tick every PIX_DIV*active_div cycles for snake movement.
- The game divisor is run-time programmable so the speed can change per level. Changes are applied glitch-free at a period boundary.

Parameters:
- PIX_DIV, 4: clock100 cycles per pix_tick. Legal range ≥1.
- GAME_W, 24: width of the game divisor and of the game counter.
- GAME_DIV_RST, 1562500: active game divisor after reset, in pix_tick units. Must be ≥1.
- CNT_W, 8: width of tick_count.

Ports:
- clock100, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- run, in, 1: 1 = game counter advances; 0 = paused.
- game_div, in, GAME_W: new divisor, in pix_tick units.
- div_load, in, 1: single-cycle strobe that captures game_div.
- pix_tick, out, 1: one-cycle pulse every PIX_DIV cycles.
- game_tick, out, 1: one-cycle pulse at each game period.
- tick_count, out, CNT_W: number of game_ticks issued, modulo 2^CNT_W.
- div_active, out, GAME_W: divisor currently in force.
- div_pending, out, 1: a loaded divisor is waiting for the next boundary.

Behaviour:
- Reset (synchronous, active-high; sampled on any edge, including mid-period):
  - pix_cnt=0, game_cnt=0.
  - pix_tick=0, game_tick=0, tick_count=0, div_pending=0.
  - div_active=GAME_DIV_RST.
  - All registers return to these values on the next edge.
- Cycle numbering: cycle 1 is the first cycle after the edge at which reset is sampled low.
- pix_cnt: counts 0..PIX_DIV-1 and wraps.
  - pix_tick is registered and is high in cycles k*PIX_DIV (k≥1).
  - PIX_DIV=1 gives pix_tick constantly 1 from cycle 1.
  - pix_tick is unaffected by run.
- game_cnt: advances only in cycles with pix_tick=1 and run=1.
  - When game_cnt=div_active-1 in such a cycle, game_cnt wraps to 0 and game_tick is high in the following cycle, for exactly one cycle.
  - Period = PIX_DIV*div_active cycles.
- tick_count increments on every game_tick; it wraps from 2^CNT_W-1 to 0.
- Divisor load:
  - div_load=1 captures game_div into a pending register and sets div_pending.
  - game_div=0 is saturated to 1.
  - A second load before the boundary overwrites the pending value.
- Divisor apply:
  - On the next game_cnt wrap, div_active takes the pending value and div_pending clears.
  - A load in the same cycle as a wrap is applied at that wrap.
  - If run=0, the pending value is applied on the next edge and game_cnt is cleared to 0.
- Pause: with run=0, game_cnt holds its value and game_tick=0.
  - When run returns to 1, counting resumes from the held value, with no extra or lost tick.
- Divisor reduced below the current game_cnt: not possible, because changes apply only at wrap or while paused.

Optional Feature:
- Macro: TICK_DIVIDER_SQUARE_OUT_EN.
- Defined:
  - Adds output clk_sq, 1 bit, reset 0. This is the compatibility output for the legacy 25 MHz consumer.
  - clk_sq toggles when pix_cnt=PIX_DIV/2-1 and when pix_cnt=PIX_DIV-1, giving a 50% duty square wave with period PIX_DIV.
  - PIX_DIV odd is an elaboration error.
- Undefined: the port and its logic are absent.

Decomposition:
- Package tick_pkg holds:
  - default constants PIX_DIV_DEF, GAME_W_DEF, GAME_DIV_RST_DEF, CNT_W_DEF;
  - the level-speed divisor constants table used by the game FSM.
- Sub-module mod_counter (params W; inputs en, modulus; outputs cnt, wrap) is instantiated for both pix_cnt and game_cnt.

Test Plan:
- Reset sequence, PIX_DIV=4 -> pix_tick high in cycles 4, 8, 12; all other outputs at reset values.
- Bench GAME_DIV_RST=3, run=1 -> game_tick in cycles 13, 25, 37; tick_count reads 1, 2, 3 after each.
- div_load game_div=5 mid-period -> div_pending=1; div_active changes to 5 only at the next wrap; next gap is 20 cycles.
- run=0 for 50 cycles mid-period, then run=1 -> no game_tick during the pause; the remaining count completes without a lost tick.
- game_div=0 loaded while paused -> div_active=1 on the next edge; game_tick every 4 cycles after run=1.
- reset asserted mid-period, and tick_count wrap from 255 to 0 with CNT_W=8 -> all outputs reset next edge; wrap is correct.

Source files
------------

// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_pkg
//  Purpose  : Shared defaults for the tick divider and the level-speed table
//             that the game FSM uses to program game_div per level.
//  Revision : 1.0 - initial release
// ============================================================================
package tick_pkg;

   // Default elaboration values for tick_divider
   localparam int PIX_DIV_DEF      = 4;
   localparam int GAME_W_DEF       = 24;
   localparam int GAME_DIV_RST_DEF = 1562500;
   localparam int CNT_W_DEF        = 8;

   // Level-speed divisors in pix_tick units, slowest level first
   localparam int LEVEL_CNT = 4;
   localparam logic [GAME_W_DEF-1:0] LEVEL_DIV [LEVEL_CNT] = '{
      24'd1562500,
      24'd1250000,
      24'd937500,
      24'd625000
   };

endpackage : tick_pkg
`default_nettype wire

// File: rtl/tick_divider_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo counter 0..modulus-1 with enable and synchronous clear.
//             wrap is combinational and flags the cycle in which the count
//             returns to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter
   import tick_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear has priority; >= keeps the counter safe if modulus shrinks
   always_comb begin
      cnt_d = cnt_q;
      wrap  = en && !clr && (cnt_q >= (modulus - W'(1)));
      if (clr) begin
         cnt_d = '0;
      end else if (wrap) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : mod_counter
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Purpose  : Single-clock enable generator. pix_tick pulses every PIX_DIV
//             cycles; game_tick pulses every PIX_DIV*div_active cycles with a
//             run-time divisor that is swapped in only at a period boundary
//             or while paused.
//  Options  : TICK_DIVIDER_SQUARE_OUT_EN adds clk_sq, a 50% square wave of
//             period PIX_DIV for the legacy 25 MHz consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_divider
   import tick_pkg::*;
#(
   parameter int PIX_DIV      = PIX_DIV_DEF,
   parameter int GAME_W       = GAME_W_DEF,
   parameter int GAME_DIV_RST = GAME_DIV_RST_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic              clock100,
   input  logic              reset,
   input  logic              run,
   input  logic [GAME_W-1:0] game_div,
   input  logic              div_load,
   output logic              pix_tick,
   output logic              game_tick,
   output logic [CNT_W-1:0]  tick_count,
   output logic [GAME_W-1:0] div_active,
`ifdef TICK_DIVIDER_SQUARE_OUT_EN
   output logic              clk_sq,
`endif
   output logic              div_pending
);

   // PIX_W holds PIX_DIV itself so the modulus is representable
   localparam int                PIX_W   = $clog2(PIX_DIV + 1);
   localparam logic [PIX_W-1:0]  PIX_MOD = PIX_W'(PIX_DIV);
   localparam logic [GAME_W-1:0] DIV_RST = GAME_W'(GAME_DIV_RST);

   logic [PIX_W-1:0]  pix_cnt;
   logic              pix_wrap;
   logic [GAME_W-1:0] game_cnt;
   logic              game_wrap;
   logic              game_en;
   logic              game_clr;
   logic [GAME_W-1:0] load_div;
   logic              apply_div;

   logic              pix_tick_q,    pix_tick_d;
   logic              game_tick_q,   game_tick_d;
   logic [CNT_W-1:0]  tick_count_q,  tick_count_d;
   logic [GAME_W-1:0] div_active_q,  div_active_d;
   logic [GAME_W-1:0] div_pend_val_q, div_pend_val_d;
   logic              div_pending_q, div_pending_d;

   mod_counter #(.W(PIX_W)) u_pix_cnt (
      .clk     (clock100),
      .rst     (reset),
      .en      (1'b1),
      .clr     (1'b0),
      .modulus (PIX_MOD),
      .cnt     (pix_cnt),
      .wrap    (pix_wrap)
   );

   mod_counter #(.W(GAME_W)) u_game_cnt (
      .clk     (clock100),
      .rst     (reset),
      .en      (game_en),
      .clr     (game_clr),
      .modulus (div_active_q),
      .cnt     (game_cnt),
      .wrap    (game_wrap)
   );

   // Divisor bookkeeping: a zero divisor is saturated to 1; a load in a wrap
   // cycle or while paused bypasses the pending register and applies at once
   always_comb begin
      game_en        = pix_tick_q && run;
      load_div       = (game_div == '0) ? GAME_W'(1) : game_div;
      apply_div      = (game_wrap || !run) && (div_load || div_pending_q);
      game_clr       = !run && (div_load || div_pending_q);
      pix_tick_d     = pix_wrap;
      game_tick_d    = game_wrap;
      tick_count_d   = game_wrap ? tick_count_q + CNT_W'(1) : tick_count_q;
      div_pend_val_d = div_load ? load_div : div_pend_val_q;
      div_active_d   = div_active_q;
      div_pending_d  = div_pending_q;
      if (apply_div) begin
         div_active_d  = div_load ? load_div : div_pend_val_q;
         div_pending_d = 1'b0;
      end else if (div_load) begin
         div_pending_d = 1'b1;
      end
   end

   // Output and divisor registers with synchronous reset
   always_ff @(posedge clock100) begin
      if (reset) begin
         pix_tick_q     <= 1'b0;
         game_tick_q    <= 1'b0;
         tick_count_q   <= '0;
         div_active_q   <= DIV_RST;
         div_pend_val_q <= DIV_RST;
         div_pending_q  <= 1'b0;
      end else begin
         pix_tick_q     <= pix_tick_d;
         game_tick_q    <= game_tick_d;
         tick_count_q   <= tick_count_d;
         div_active_q   <= div_active_d;
         div_pend_val_q <= div_pend_val_d;
         div_pending_q  <= div_pending_d;
      end
   end

   assign pix_tick    = pix_tick_q;
   assign game_tick   = game_tick_q;
   assign tick_count  = tick_count_q;
   assign div_active  = div_active_q;
   assign div_pending = div_pending_q;

`ifdef TICK_DIVIDER_SQUARE_OUT_EN
   generate
      if ((PIX_DIV % 2) != 0) begin : g_sq_odd_err
         $error("tick_divider: clk_sq needs an even PIX_DIV");
      end
   endgenerate

   logic clk_sq_q, clk_sq_d;

   // Toggle at mid-period and end-of-period for a 50% duty square wave
   always_comb begin
      clk_sq_d = clk_sq_q;
      if ((pix_cnt == PIX_W'(PIX_DIV / 2 - 1)) || (pix_cnt == PIX_W'(PIX_DIV - 1))) begin
         clk_sq_d = ~clk_sq_q;
      end
   end

   // Square-wave register with synchronous reset
   always_ff @(posedge clock100) begin
      if (reset) begin
         clk_sq_q <= 1'b0;
      end else begin
         clk_sq_q <= clk_sq_d;
      end
   end

   assign clk_sq = clk_sq_q;
`endif

   // Counter values are only observed through the wrap strobes in this build
   logic unused_cnt;
   assign unused_cnt = ^{pix_cnt, game_cnt};

endmodule : tick_divider
`default_nettype wire
